// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : ALUControl code constants and execute-stage state encoding.
// Revision : 1.0
// ============================================================================
package alu_pkg;

   localparam int ALU_CODE_WIDTH = 3;

   localparam logic [ALU_CODE_WIDTH-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_CODE_WIDTH-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_CODE_WIDTH-1:0] ALU_AND = 3'b010;
   localparam logic [ALU_CODE_WIDTH-1:0] ALU_OR  = 3'b011;
   localparam logic [ALU_CODE_WIDTH-1:0] ALU_SLT = 3'b101;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_e;

endpackage
`default_nettype wire

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_if
// Purpose  : Upstream/downstream handshake and payload bundle of the execute stage.
// Revision : 1.0
// ============================================================================
interface execute_stage_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int ALU_CTRL_WIDTH = 3,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      in_valid;
   logic                      in_ready;
   logic [ALU_CTRL_WIDTH-1:0] ALUControl;
   logic [DATA_WIDTH-1:0]     src_a;
   logic [DATA_WIDTH-1:0]     src_b;
   logic [REG_ADDR_WIDTH-1:0] rd;
   logic                      reg_write;
   logic                      flush;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_WIDTH-1:0]     alu_result;
   logic                      zero;
   logic [REG_ADDR_WIDTH-1:0] out_rd;
   logic                      out_reg_write;

   modport master (
      output in_valid, ALUControl, src_a, src_b, rd, reg_write, flush, out_ready,
      input  in_ready, out_valid, alu_result, zero, out_rd, out_reg_write
   );

   modport slave (
      input  in_valid, ALUControl, src_a, src_b, rd, reg_write, flush, out_ready,
      output in_ready, out_valid, alu_result, zero, out_rd, out_reg_write
   );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Combinational ALU; unlisted codes fall back to add.
// Revision : 1.0
// ============================================================================
module alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ALU_CTRL_WIDTH = 3
) (
   input  logic [DATA_WIDTH-1:0]     src_a,
   input  logic [DATA_WIDTH-1:0]     src_b,
   input  logic [ALU_CTRL_WIDTH-1:0] ALUControl,
   output logic [DATA_WIDTH-1:0]     result
);

   logic w_less;

   assign w_less = $signed(src_a) < $signed(src_b);

   always_comb begin
      result = src_a + src_b;
      case (ALUControl)
         ALU_CTRL_WIDTH'(ALU_SUB): result = src_a - src_b;
         ALU_CTRL_WIDTH'(ALU_AND): result = src_a & src_b;
         ALU_CTRL_WIDTH'(ALU_OR):  result = src_a | src_b;
         ALU_CTRL_WIDTH'(ALU_SLT): result = {{(DATA_WIDTH-1){1'b0}}, w_less};
         default:                  result = src_a + src_b;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Purpose  : Single-entry registered execute stage with valid/ready handshake.
// Revision : 1.0
// ============================================================================
module execute_stage
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ALU_CTRL_WIDTH = 3,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic           clk,
   input  logic           rst,
   execute_stage_if.slave bus
);

   stage_state_e              r_state;
   stage_state_e              w_state_next;
   logic [DATA_WIDTH-1:0]     w_alu_out;
   logic                      w_in_ready;
   logic                      w_accept;
   logic [DATA_WIDTH-1:0]     r_alu_result;
   logic                      r_zero;
   logic [REG_ADDR_WIDTH-1:0] r_out_rd;
   logic                      r_out_reg_write;

   alu #(
      .DATA_WIDTH     (DATA_WIDTH),
      .ALU_CTRL_WIDTH (ALU_CTRL_WIDTH)
   ) u_alu (
      .src_a      (bus.src_a),
      .src_b      (bus.src_b),
      .ALUControl (bus.ALUControl),
      .result     (w_alu_out)
   );

   assign w_in_ready = ((r_state == ST_EMPTY) || bus.out_ready) && !bus.flush;
   assign w_accept   = bus.in_valid && w_in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // flush dominates; an accept while FULL keeps the stage FULL (consume+replace)
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
         ST_FULL: begin
            if (bus.flush)          w_state_next = ST_EMPTY;
            else if (w_accept)      w_state_next = ST_FULL;
            else if (bus.out_ready) w_state_next = ST_EMPTY;
         end
         default: w_state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_result    <= '0;
         r_zero          <= 1'b0;
         r_out_rd        <= '0;
         r_out_reg_write <= 1'b0;
      end else if (bus.flush) begin
         r_out_reg_write <= 1'b0;
      end else if (w_accept) begin
         r_alu_result    <= w_alu_out;
         r_zero          <= (w_alu_out == '0);
         r_out_rd        <= bus.rd;
         r_out_reg_write <= bus.reg_write;
      end
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.out_valid     = (r_state == ST_FULL);
   assign bus.alu_result    = r_alu_result;
   assign bus.zero          = r_zero;
   assign bus.out_rd        = r_out_rd;
   assign bus.out_reg_write = r_out_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Directed self-checking bench for execute_stage.
// Revision : 1.0
// ============================================================================
module tb_execute_stage;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   execute_stage_if #(.DATA_WIDTH(32), .ALU_CTRL_WIDTH(3), .REG_ADDR_WIDTH(5)) bus ();

   execute_stage #(
      .DATA_WIDTH     (32),
      .ALU_CTRL_WIDTH (3),
      .REG_ADDR_WIDTH (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dst, input logic we);
      bus.in_valid   = 1'b1;
      bus.ALUControl = code;
      bus.src_a      = a;
      bus.src_b      = b;
      bus.rd         = dst;
      bus.reg_write  = we;
   endtask

   // single accept followed by an idle input; result observed one edge later
   task automatic do_op(input string tag, input logic [2:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero);
      drive(code, a, b, 5'd9, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      check_value({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      check_value({tag, "_result"}, 64'(bus.alu_result), 64'(exp_res));
      check_value({tag, "_zero"}, 64'(bus.zero), 64'(exp_zero));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.ALUControl = 3'b000;
      bus.src_a = '0;
      bus.src_b = '0;
      bus.rd = '0;
      bus.reg_write = 1'b0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_value("rst_valid", 64'(bus.out_valid), 64'd0);
      check_value("rst_result", 64'(bus.alu_result), 64'd0);
      check_value("rst_zero", 64'(bus.zero), 64'd0);
      check_value("rst_rd", 64'(bus.out_rd), 64'd0);
      check_value("rst_we", 64'(bus.out_reg_write), 64'd0);
      check_value("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // ALU function vectors
      drive(3'b000, 32'd5, 32'd7, 5'd3, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      check_value("add_valid", 64'(bus.out_valid), 64'd1);
      check_value("add_result", 64'(bus.alu_result), 64'd12);
      check_value("add_zero", 64'(bus.zero), 64'd0);
      check_value("add_rd", 64'(bus.out_rd), 64'd3);
      check_value("add_we", 64'(bus.out_reg_write), 64'd1);
      tick();
      check_value("drain_valid", 64'(bus.out_valid), 64'd0);

      do_op("sub_eq",   3'b001, 32'd9, 32'd9, 32'd0, 1'b1);
      do_op("sub_wrap", 3'b001, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
      do_op("and",      3'b010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
      do_op("or",       3'b011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0);
      do_op("slt_neg",  3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
      do_op("slt_pos",  3'b101, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
      do_op("code111",  3'b111, 32'd3, 32'd4, 32'd7, 1'b0);
      do_op("code100",  3'b100, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
      do_op("code110",  3'b110, 32'd10, 32'd20, 32'd30, 1'b0);
      tick();

      // stall: held result must stay put for three cycles
      drive(3'b000, 32'd1, 32'd1, 5'd4, 1'b1);
      tick();
      bus.out_ready = 1'b0;
      drive(3'b000, 32'd10, 32'd10, 5'd7, 1'b0);
      #1;
      for (int i = 0; i < 3; i++) begin
         check_value("stall_in_ready", 64'(bus.in_ready), 64'd0);
         tick();
         check_value("stall_valid", 64'(bus.out_valid), 64'd1);
         check_value("stall_result", 64'(bus.alu_result), 64'd2);
         check_value("stall_rd", 64'(bus.out_rd), 64'd4);
      end
      bus.out_ready = 1'b1;
      #1;
      check_value("unstall_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      check_value("unstall_result", 64'(bus.alu_result), 64'd20);
      check_value("unstall_rd", 64'(bus.out_rd), 64'd7);
      check_value("unstall_we", 64'(bus.out_reg_write), 64'd0);

      // back-to-back throughput
      for (int i = 0; i < 4; i++) begin
         drive(3'b000, 32'(100 * i), 32'(i + 1), 5'(i), 1'b1);
         tick();
         check_value("b2b_valid", 64'(bus.out_valid), 64'd1);
         check_value("b2b_result", 64'(bus.alu_result), 64'(101 * i + 1));
         check_value("b2b_rd", 64'(bus.out_rd), 64'(i));
      end
      bus.in_valid = 1'b0;
      tick();
      check_value("b2b_drain", 64'(bus.out_valid), 64'd0);

      // flush while FULL and stalled
      drive(3'b011, 32'd5, 32'd0, 5'd2, 1'b1);
      tick();
      bus.out_ready = 1'b0;
      bus.flush = 1'b1;
      #1;
      check_value("flush_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      check_value("flush_valid", 64'(bus.out_valid), 64'd0);
      check_value("flush_we", 64'(bus.out_reg_write), 64'd0);

      // reset beats flush and a pending accept, discarding the stalled op
      bus.out_ready = 1'b1;
      drive(3'b000, 32'd8, 32'd8, 5'd6, 1'b1);
      tick();
      bus.out_ready = 1'b0;
      check_value("pre_rst_valid", 64'(bus.out_valid), 64'd1);
      rst = 1'b1;
      bus.flush = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      rst = 1'b0;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      check_value("rst2_valid", 64'(bus.out_valid), 64'd0);
      check_value("rst2_result", 64'(bus.alu_result), 64'd0);
      check_value("rst2_zero", 64'(bus.zero), 64'd0);
      check_value("rst2_rd", 64'(bus.out_rd), 64'd0);
      check_value("rst2_we", 64'(bus.out_reg_write), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning ALU operand and result width.
REQ-002 The module SHALL have parameter ALU_CTRL_WIDTH, default 3, meaning ALUControl code width.
REQ-003 The module SHALL have parameter REG_ADDR_WIDTH, default 5, meaning destination register index width.
REQ-004 The module SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 The module SHALL have port in_valid, input, 1, meaning the upstream operation is present.
REQ-007 The module SHALL have port in_ready, output, 1, meaning the stage accepts an operation this cycle.
REQ-008 The module SHALL have port ALUControl, input, ALU_CTRL_WIDTH, meaning the operation code from the ALU decoder.
REQ-009 The module SHALL have ports src_a and src_b, input, DATA_WIDTH each, meaning the operands.
REQ-010 The module SHALL have ports rd (input, REG_ADDR_WIDTH) and reg_write (input, 1), meaning writeback tag and enable, passed through.
REQ-011 The module SHALL have port flush, input, 1, meaning kill the held and the incoming operation.
REQ-012 The module SHALL have port out_valid, output, 1, meaning the result register holds a live operation.
REQ-013 The module SHALL have port out_ready, input, 1, meaning downstream consumes the result this cycle.
REQ-014 The module SHALL have ports alu_result (output, DATA_WIDTH), zero (output, 1), out_rd (output, REG_ADDR_WIDTH) and out_reg_write (output, 1), all registered.

Function
REQ-015 ALUControl codes SHALL be: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed); every other code SHALL execute add.
REQ-016 add and sub SHALL wrap modulo 2^DATA_WIDTH; slt SHALL yield 1 or 0, zero-extended to DATA_WIDTH.
REQ-017 zero SHALL be 1 exactly when the registered alu_result equals 0.
REQ-018 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-019 An accept (in_valid && in_ready) SHALL load alu_result, zero, out_rd, out_reg_write and set out_valid on the same edge: latency one cycle.
REQ-020 Without an accept, out_valid && out_ready SHALL clear out_valid on the edge.
REQ-021 Simultaneous consume and accept SHALL replace the result with the new operation, out_valid staying 1 (full throughput, one op per cycle).
REQ-022 While out_valid && !out_ready, all outputs SHALL hold stable and no new operation SHALL be accepted.
REQ-023 flush SHALL clear out_valid and out_reg_write on the next edge, regardless of out_ready and in_valid.
REQ-024 The stage SHALL have two states, EMPTY (out_valid=0) and FULL (out_valid=1), transitioning only as in REQ-019 to REQ-023.

Reset
REQ-025 rst SHALL force out_valid=0, alu_result=0, zero=0, out_rd=0 and out_reg_write=0 on the next edge.
REQ-026 rst SHALL take priority over flush and any accept in the same cycle; mid-stall, the held operation SHALL be discarded.

Structure
REQ-027 ALUControl code constants SHALL reside in a shared package alu_pkg, used by this block and the ALU decoder.
REQ-028 The combinational datapath SHALL be a sub-module alu (src_a, src_b, ALUControl -> result); this block SHALL hold only registers and handshake logic.

Verification
REQ-029 Accept 000, src_a=5, src_b=7 -> next cycle out_valid=1, alu_result=12, zero=0.
REQ-030 Accept 001, src_a=9, src_b=9 -> alu_result=0, zero=1; accept 001, 0 and 1 -> alu_result=0xFFFFFFFF.
REQ-031 Accept 101, src_a=0xFFFFFFFF, src_b=1 -> alu_result=1; accept code 111, 3 and 4 -> alu_result=7.
REQ-032 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged; then out_ready=1 -> next op loads on the following edge.
REQ-033 Back-to-back accepts with out_ready=1 for 4 cycles -> 4 consecutive results, out_valid continuously 1.
REQ-034 Assert flush while FULL and stalled -> out_valid=0 and out_reg_write=0 next cycle; rst with flush and in_valid -> all outputs 0.
